// File: rtl/display_sched_pkg.sv
// ============================================================================
// display_sched_pkg : message codes, FSM states and one-hot decode shared by
//                     the display status scheduler.   Rev 1.0
// ============================================================================
`default_nettype none

package display_sched_pkg;

  // Numeric order equals display priority, so preemption is a plain compare.
  typedef enum logic [2:0] {
    NONE  = 3'd0,
    LIVRE = 3'd1,
    PARE  = 3'd2,
    FULL  = 3'd3,
    ERRO  = 3'd4
  } msg_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  // Bit order {Erro, Full, Pare, Livre}.
  function automatic logic [3:0] msg_to_onehot(input msg_t m);
    logic [3:0] oh;
    oh = 4'b0000;
    case (m)
      LIVRE:   oh = 4'b0001;
      PARE:    oh = 4'b0010;
      FULL:    oh = 4'b0100;
      ERRO:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_status_scheduler_tick_prescaler.sv
// ============================================================================
// tick_prescaler : free-running divider, one-cycle tick every TICK_DIV clocks.
//                  Rev 1.0
// ============================================================================
`default_nettype none

module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic Clock,
  input  logic Reset,
  output logic tick
);

  localparam int                 c_CNT_W = $clog2(TICK_DIV);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TICK_DIV - 1);

  logic [c_CNT_W-1:0] cnt_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (cnt_q == c_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + c_CNT_W'(1);
    end
  end

  assign tick = (cnt_q == c_LAST);

endmodule

`default_nettype wire

// File: rtl/display_status_scheduler.sv
// ============================================================================
// display_status_scheduler : priority arbitration + minimum hold for the 7-seg
//   message select. Optional Erro blink: DISPLAY_SCHED_BLINK_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module display_status_scheduler
  import display_sched_pkg::*;
#(
  parameter int TICK_DIV    = 50000,
  parameter int HOLD_TICKS  = 500,
  parameter int BLINK_TICKS = 250
) (
  input  logic Clock,
  input  logic Reset,
  input  logic ReqLivre,
  input  logic ReqPare,
  input  logic ReqErro,
  input  logic ReqFull,
  output logic Livre,
  output logic Pare,
  output logic Erro,
  output logic Full,
  output logic Ativo,
  output logic Mudou
);

  localparam int                  c_HOLD_W   = $clog2(HOLD_TICKS + 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(HOLD_TICKS);

  if (TICK_DIV < 2 || HOLD_TICKS < 1 || BLINK_TICKS < 1) begin : g_param_check
    $error("display_status_scheduler: illegal parameter value");
  end

  logic                tick;
  state_t              state_q, state_d;
  msg_t                cur_q, cur_d;
  msg_t                winner;
  logic [c_HOLD_W-1:0] hold_q, hold_d;
  logic                changed;
  logic                erro_gate;
  logic [3:0]          sel_q;
  logic                ativo_q;
  logic                mudou_q;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .Clock (Clock),
    .Reset (Reset),
    .tick  (tick)
  );

  always_comb begin
    winner = NONE;
    if      (ReqErro)  winner = ERRO;
    else if (ReqFull)  winner = FULL;
    else if (ReqPare)  winner = PARE;
    else if (ReqLivre) winner = LIVRE;
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (winner != NONE) begin
          state_d = SHOW;
          cur_d   = winner;
          hold_d  = '0;
        end
      end
      SHOW: begin
        // A switch cycle restarts the hold, so a coincident tick is dropped.
        if (winner > cur_q || (winner != cur_q && hold_q == c_HOLD_MAX)) begin
          cur_d  = winner;
          hold_d = '0;
          if (winner == NONE) state_d = IDLE;
        end else if (tick && hold_q != c_HOLD_MAX) begin
          hold_d = hold_q + c_HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign changed = (cur_d != cur_q);

`ifdef DISPLAY_SCHED_BLINK_EN
  localparam int                   c_BLINK_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_TICKS - 1);

  logic [c_BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic                 phase_q, phase_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (changed || cur_q != ERRO) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (tick) begin
      if (blink_cnt_q == c_BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + c_BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign erro_gate = phase_d;
`else
  assign erro_gate = 1'b1;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cur_q   <= NONE;
      hold_q  <= '0;
      sel_q   <= '0;
      ativo_q <= 1'b0;
      mudou_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      hold_q  <= hold_d;
      sel_q   <= msg_to_onehot(cur_d) & {erro_gate, 3'b111};
      ativo_q <= (state_d == SHOW);
      mudou_q <= changed;
    end
  end

  assign Livre = sel_q[0];
  assign Pare  = sel_q[1];
  assign Full  = sel_q[2];
  assign Erro  = sel_q[3];
  assign Ativo = ativo_q;
  assign Mudou = mudou_q;

endmodule

`default_nettype wire
